// File: rtl/periph_bus_pkg.sv
// Shared types and default memory map for the peripheral bus interconnect.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package periph_bus_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        WAIT     = 2'd2,
        RESP_ERR = 2'd3
    } state_t;

    // Bit positions inside err_flags
    localparam int ERR_UNMAPPED = 0;
    localparam int ERR_TIMEOUT  = 1;

    // Default map: 0=RAM, 1=LEDs, 2=switches, 3=keys, 4=7-seg
    localparam logic [5*32-1:0] DEF_SLV_BASE =
        {32'h0000_4010, 32'h0000_4008, 32'h0000_4004, 32'h0000_4000, 32'h0000_0000};
    localparam logic [5*32-1:0] DEF_SLV_MASK =
        {32'hFFFF_FFF0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_F000};

endpackage

// File: rtl/periph_addr_decode.sv
// Mask/base address decode: per-slave hit vector, lowest-index winner, unmapped flag.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module periph_addr_decode #(
    parameter int NUM_SLAVES = 5,
    parameter int ADDR_WIDTH = 32,
    parameter int IW         = 3,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK = '0
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [NUM_SLAVES-1:0] hit,
    output logic [IW-1:0]         hit_idx,
    output logic                  unmapped
);

    // Compare masked address against every window; scan downwards so the lowest index wins
    always_comb begin
        hit     = '0;
        hit_idx = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            hit[i] = ((addr & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                      SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]);
        end
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_idx = IW'(i);
            end
        end
        unmapped = ~|hit;
    end

endmodule

// File: rtl/periph_bus_mux.sv
// Memory-mapped interconnect from the DLX data port to NUM_SLAVES peripherals.
// Latency: write 1 cycle, read 2 (comb slave) / 3 (1-cycle RAM) / TIMEOUT+2 (no answer).
// Backpressure: one transaction in flight; requests seen while m_busy=1 are ignored.
module periph_bus_mux
    import periph_bus_pkg::*;
#(
    parameter int NUM_SLAVES = 5,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK = DEF_SLV_MASK,
    parameter int TIMEOUT = 15,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [ADDR_WIDTH-1:0]            m_addr,
    input  logic [DATA_WIDTH-1:0]            m_wdata,
    input  logic                             m_we,
    input  logic                             m_re,
    output logic [DATA_WIDTH-1:0]            m_rdata,
    output logic                             m_rvalid,
    output logic                             m_wdone,
    output logic                             m_busy,
    output logic [NUM_SLAVES-1:0]            s_cs,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    output logic                             s_we,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]            s_rvalid,
    input  logic                             err_clr,
    output logic [1:0]                       err_flags
);

    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT);

    state_t                state, state_nxt;
    logic [NUM_SLAVES-1:0] hit;
    logic [IW-1:0]         hit_idx;
    logic                  unmapped;
    logic [IW-1:0]         idx_q;
    logic                  we_q;
    logic [CW-1:0]         cnt;
    logic                  req;
    logic                  sel_rvalid;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic [1:0]            err_set;

    periph_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .IW         (IW),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_decode (
        .addr     (m_addr),
        .hit      (hit),
        .hit_idx  (hit_idx),
        .unmapped (unmapped)
    );

    // Write wins over read when both are raised together
    assign req        = m_we | m_re;
    // Only the latched slave's valid/data is ever looked at
    assign sel_rvalid = s_rvalid[idx_q];
    assign sel_rdata  = s_rdata[idx_q*DATA_WIDTH +: DATA_WIDTH];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (req) state_nxt = unmapped ? RESP_ERR : ACCESS;
            ACCESS:   if (we_q || sel_rvalid) state_nxt = IDLE;
                      else state_nxt = WAIT;
            WAIT:     if (sel_rvalid || cnt == CNT_LAST) state_nxt = IDLE;
            RESP_ERR: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs: selects, strobes and error-flag set requests
    always_comb begin
        m_busy  = (state != IDLE);
        s_cs    = '0;
        s_we    = 1'b0;
        m_wdone = 1'b0;
        err_set = 2'b00;
        if (state == ACCESS || state == WAIT) begin
            s_cs[idx_q] = 1'b1;
        end
        if (state == ACCESS) begin
            s_we    = we_q;
            m_wdone = we_q;
        end
        if (state == RESP_ERR) begin
            m_wdone               = we_q;
            err_set[ERR_UNMAPPED] = 1'b1;
        end
        if (state == WAIT && !sel_rvalid && cnt == CNT_LAST) begin
            err_set[ERR_TIMEOUT] = 1'b1;
        end
    end

    // Request capture, read-data return, wait counter and sticky error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q     <= '0;
            we_q      <= 1'b0;
            cnt       <= '0;
            s_addr    <= '0;
            s_wdata   <= '0;
            m_rdata   <= '0;
            m_rvalid  <= 1'b0;
            err_flags <= 2'b00;
        end else begin
            m_rvalid  <= 1'b0;
            // A flag set in the same cycle as err_clr survives
            err_flags <= (err_flags & ~{2{err_clr}}) | err_set;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q <= m_we;
                        if (!unmapped) begin
                            idx_q   <= hit_idx;
                            s_addr  <= m_addr;
                            s_wdata <= m_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        if (sel_rvalid) begin
                            m_rdata  <= sel_rdata;
                            m_rvalid <= 1'b1;
                        end else begin
                            cnt <= CW'(1);
                        end
                    end
                end
                WAIT: begin
                    if (sel_rvalid) begin
                        m_rdata  <= sel_rdata;
                        m_rvalid <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        m_rdata  <= ERR_DATA;
                        m_rvalid <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP_ERR: begin
                    if (!we_q) begin
                        m_rdata  <= ERR_DATA;
                        m_rvalid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_periph_bus_mux.sv
// Directed bench for periph_bus_mux: default map instance plus an overlapping-map instance.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Single request pulse per transaction; slaves modelled by direct stimulus.
module tb_periph_bus_mux;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   m_addr, m_wdata;
    logic          m_we, m_re;
    logic [31:0]   m_rdata;
    logic          m_rvalid, m_wdone, m_busy;
    logic [4:0]    s_cs;
    logic [31:0]   s_addr, s_wdata;
    logic          s_we;
    logic [159:0]  s_rdata;
    logic [4:0]    s_rvalid;
    logic          err_clr;
    logic [1:0]    err_flags;

    logic [31:0]   o_rdata, o_saddr, o_swdata;
    logic          o_rvalid, o_wdone, o_busy, o_swe;
    logic [4:0]    o_cs;
    logic [1:0]    o_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    periph_bus_mux u_dut (
        .clk(clk), .reset(reset), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_we(m_we), .m_re(m_re), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
        .m_wdone(m_wdone), .m_busy(m_busy), .s_cs(s_cs), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_we(s_we), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
        .err_clr(err_clr), .err_flags(err_flags)
    );

    // Slave 1 window widened to also cover address 0x0 to exercise priority
    periph_bus_mux #(
        .SLV_BASE({32'h4010, 32'h4008, 32'h4004, 32'h0000, 32'h0000}),
        .SLV_MASK({32'hFFFFFFF0, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFF000, 32'hFFFFF000})
    ) u_ovl (
        .clk(clk), .reset(reset), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_we(m_we), .m_re(m_re), .m_rdata(o_rdata), .m_rvalid(o_rvalid),
        .m_wdone(o_wdone), .m_busy(o_busy), .s_cs(o_cs), .s_addr(o_saddr),
        .s_wdata(o_swdata), .s_we(o_swe), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
        .err_clr(err_clr), .err_flags(o_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int lat;
        bit got;

        reset    = 1'b1;
        m_addr   = '0;
        m_wdata  = '0;
        m_we     = 1'b0;
        m_re     = 1'b0;
        s_rvalid = '0;
        err_clr  = 1'b0;
        s_rdata  = {32'h4444_0004, 32'hAAAA_5555, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};
        idle(2);
        reset = 1'b0;

        // Reset state
        chk("rst_busy",   32'(m_busy),    32'd0);
        chk("rst_cs",     32'(s_cs),      32'd0);
        chk("rst_rvalid", 32'(m_rvalid),  32'd0);
        chk("rst_rdata",  m_rdata,        32'd0);
        chk("rst_err",    32'(err_flags), 32'd0);
        chk("rst_saddr",  s_addr,         32'd0);

        // RAM read, data one cycle after select
        m_re = 1'b1; m_addr = 32'h0000_0010;
        tick();                                   // request sampled, ACCESS
        m_re = 1'b0;
        chk("ram_cs",     32'(s_cs),   32'b00001);
        chk("ram_ovl_cs", 32'(o_cs),   32'b00001);
        chk("ram_busy",   32'(m_busy), 32'd1);
        tick();                                   // WAIT, RAM answers
        s_rvalid[0] = 1'b1; s_rdata[31:0] = 32'h1234_5678;
        chk("ram_rv_early", 32'(m_rvalid), 32'd0);
        tick();                                   // cycle 3: response
        s_rvalid[0] = 1'b0;
        chk("ram_rvalid", 32'(m_rvalid),  32'd1);
        chk("ram_rdata",  m_rdata,        32'h1234_5678);
        chk("ram_err",    32'(err_flags), 32'd0);
        chk("ram_idle",   32'(m_busy),    32'd0);
        tick();
        chk("ram_pulse",  32'(m_rvalid),  32'd0);
        chk("ram_hold",   m_rdata,        32'h1234_5678);
        idle(2);

        // LED write
        m_we = 1'b1; m_addr = 32'h0000_4000; m_wdata = 32'h0000_03FF;
        tick();
        m_we = 1'b0;
        chk("wr_cs",    32'(s_cs),    32'b00010);
        chk("wr_swe",   32'(s_we),    32'd1);
        chk("wr_wdata", s_wdata,      32'h0000_03FF);
        chk("wr_saddr", s_addr,       32'h0000_4000);
        chk("wr_wdone", 32'(m_wdone), 32'd1);
        tick();
        chk("wr_cs_off",  32'(s_cs),    32'd0);
        chk("wr_swe_off", 32'(s_we),    32'd0);
        chk("wr_done_off",32'(m_wdone), 32'd0);
        idle(2);

        // Unmapped read
        m_re = 1'b1; m_addr = 32'h0000_8000;
        tick();
        m_re = 1'b0;
        chk("um_cs",    32'(s_cs),     32'd0);
        chk("um_rv1",   32'(m_rvalid), 32'd0);
        tick();
        chk("um_rvalid", 32'(m_rvalid),  32'd1);
        chk("um_rdata",  m_rdata,        32'hDEAD_BEEF);
        chk("um_err",    32'(err_flags), 32'b01);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("um_clr",    32'(err_flags), 32'b00);
        idle(2);

        // Keys read that never answers; RAM valid is noise; err_clr collides with timeout set
        m_re = 1'b1; m_addr = 32'h0000_4008;
        tick();
        m_re = 1'b0;
        s_rvalid[0] = 1'b1;
        chk("to_cs", 32'(s_cs), 32'b01000);
        lat = 0; got = 0;
        for (int k = 1; k <= 40 && !got; k++) begin
            tick();
            lat = k + 1;
            err_clr = (k == 15);
            if (m_rvalid) got = 1;
        end
        err_clr = 1'b0;
        s_rvalid[0] = 1'b0;
        chk("to_seen",  32'(got),       32'd1);
        chk("to_lat",   32'(lat),       32'd17);
        chk("to_rdata", m_rdata,        32'hDEAD_BEEF);
        chk("to_err",   32'(err_flags), 32'b10);
        chk("to_cs_off",32'(s_cs),      32'd0);
        idle(2);

        // Write and read raised together: behaves as a write
        m_we = 1'b1; m_re = 1'b1; m_addr = 32'h0000_4010; m_wdata = 32'h0000_007F;
        tick();
        m_we = 1'b0; m_re = 1'b0;
        chk("both_cs",    32'(s_cs),    32'b10000);
        chk("both_swe",   32'(s_we),    32'd1);
        chk("both_wdone", 32'(m_wdone), 32'd1);
        tick();
        chk("both_norv",  32'(m_rvalid), 32'd0);
        idle(2);

        // Read slave 0, ignore a request during WAIT, then reset mid-transaction
        m_re = 1'b1; m_addr = 32'h0000_0000;
        tick();
        m_re = 1'b0;
        chk("ovl_cs", 32'(o_cs), 32'b00001);
        tick();                                   // WAIT
        m_we = 1'b1; m_addr = 32'h0000_4000; m_wdata = 32'h55;
        tick();
        chk("ign_cs",    32'(s_cs),   32'b00001);
        chk("ign_swe",   32'(s_we),   32'd0);
        chk("ign_saddr", s_addr,      32'h0000_0000);
        reset = 1'b1; m_we = 1'b0;
        tick();
        reset = 1'b0;
        chk("mrst_cs",   32'(s_cs),      32'd0);
        chk("mrst_busy", 32'(m_busy),    32'd0);
        chk("mrst_rv",   32'(m_rvalid),  32'd0);
        chk("mrst_err",  32'(err_flags), 32'd0);
        tick();
        chk("mrst_rv2",  32'(m_rvalid),  32'd0);
        chk("mrst_busy2",32'(m_busy),    32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/periph_bus_mux.md
Name: periph_bus_mux

Overview:
- Parametrised memory-mapped peripheral interconnect between the DLX data port and NUM_SLAVES peripherals (RAM, LEDs, switches, keys, 7-seg, future devices).
- Replaces the ad-hoc chip-select plus registered read mux at SoC top level.
- Adds mask/base address decode per slave, a per-transaction handshake with variable-latency slaves, a read timeout, and sticky error flags for unmapped and timed-out accesses.

Parameters:
- NUM_SLAVES, 5, number of slave ports.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- SLV_BASE, {32'h4010,32'h4008,32'h4004,32'h4000,32'h0}, packed bases; slave i occupies [i*ADDR_WIDTH +: ADDR_WIDTH]. Defaults: 0=RAM, 1=LEDs, 2=switches, 3=keys, 4=7-seg.
- SLV_MASK, {32'hFFFFFFF0,32'hFFFFFFFC,32'hFFFFFFFC,32'hFFFFFFFC,32'hFFFFF000}, packed masks, same packing as SLV_BASE.
- TIMEOUT, 15, maximum cycles to wait for slave read valid.
- ERR_DATA, 32'hDEADBEEF, read data returned on unmapped or timed-out reads.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- m_addr  in  ADDR_WIDTH  master address.
- m_wdata  in  DATA_WIDTH  master write data.
- m_we  in  1  write request.
- m_re  in  1  read request.
- m_rdata  out  DATA_WIDTH  read data, registered.
- m_rvalid  out  1  one-cycle pulse; read data valid.
- m_wdone  out  1  one-cycle pulse; write accepted.
- m_busy  out  1  transaction in flight.
- s_cs  out  NUM_SLAVES  one-hot slave select.
- s_addr  out  ADDR_WIDTH  registered address to slaves.
- s_wdata  out  DATA_WIDTH  registered write data.
- s_we  out  1  registered write enable.
- s_rdata  in  NUM_SLAVES*DATA_WIDTH  packed slave read data.
- s_rvalid  in  NUM_SLAVES  per-slave read valid.
- err_clr  in  1  clear sticky error flags.
- err_flags  out  2  sticky flags: bit0 unmapped, bit1 timeout.

Behaviour:
- Reset: state IDLE; all outputs 0 (m_rdata, m_rvalid, m_wdone, m_busy, s_cs, s_addr, s_wdata, s_we, err_flags).
- Decode (combinational): slave i hits when (m_addr & MASK[i]) == BASE[i]. On multiple hits the lowest index wins. No hit means unmapped.
- IDLE:
  - Request is m_we|m_re; m_we takes precedence when both are set.
  - Hit: latch index, m_addr, m_wdata, m_we into the s_* registers; next state ACCESS.
  - Unmapped: next state RESP_ERR.
  - m_busy=0 only in IDLE.
- ACCESS (s_cs[idx]=1, s_we per request):
  - Write: m_wdone=1 this cycle; s_cs and s_we drop next cycle; next state IDLE.
  - Read: if s_rvalid[idx]=1, capture s_rdata[idx] into m_rdata and pulse m_rvalid next cycle; next state IDLE. Otherwise next state WAIT with cnt=1.
- WAIT (s_cs[idx] held, s_we=0):
  - s_rvalid[idx]=1: capture data as above; next state IDLE.
  - Else if cnt==TIMEOUT: m_rdata=ERR_DATA, pulse m_rvalid, set err_flags[1]; next state IDLE.
  - Else cnt++. cnt width is $clog2(TIMEOUT+1).
- RESP_ERR (one cycle):
  - Read: m_rdata=ERR_DATA, m_rvalid=1.
  - Write: m_wdone=1; write is dropped.
  - Both cases set err_flags[0]; next state IDLE.
- Latency, request sampled to response pulse:
  - Write: 1 cycle.
  - Read from combinational slave (valid in ACCESS): 2 cycles.
  - Read from 1-cycle RAM: 3 cycles.
  - Timeout: TIMEOUT+2 cycles.
- Requests while m_busy=1 are ignored. The master holds the request until m_rvalid or m_wdone.
- s_rvalid from a non-selected slave is ignored.
- m_rdata holds its value between responses.
- err_flags: when err_clr and a flag set happen in the same cycle, the set wins.
- Reset mid-transaction: return to IDLE with s_cs=0; no response pulse is generated.

Decomposition:
- Package periph_bus_pkg:
  - state enum {IDLE, ACCESS, WAIT, RESP_ERR};
  - ERR_UNMAPPED=0 and ERR_TIMEOUT=1 bit indices;
  - default map constants (bases and masks).
- Sub-module periph_addr_decode (combinational, parametrised): produces hit vector, priority index, and unmapped flag.

Test Plan:
- Read RAM addr 0x0000_0010 with RAM rvalid 1 cycle after cs, rdata 0x12345678 -> s_cs=5'b00001; m_rvalid 3 cycles after request with m_rdata=0x12345678; err_flags=0.
- Write 0x3FF to 0x0000_4000 -> s_cs=5'b00010, s_we=1, s_wdata=0x3FF for one cycle; m_wdone 1 cycle after request.
- Read 0x0000_8000 (unmapped) -> m_rvalid with m_rdata=0xDEADBEEF 2 cycles after request; err_flags=2'b01; err_clr -> 2'b00 next cycle.
- Read 0x0000_4008 (keys) with s_rvalid stuck at 0 -> m_rvalid with 0xDEADBEEF 17 cycles after request; err_flags[1]=1; s_cs deasserted afterwards.
- Overlapping map, slave1 also matching 0x0 -> read 0x0 selects slave0 only; new request during WAIT is ignored; reset asserted in WAIT -> s_cs=0, m_busy=0, no m_rvalid.
- Simultaneous m_we & m_re to 0x0000_4010 -> treated as write (s_we=1, m_wdone=1, no m_rvalid); err_clr in the same cycle as a timeout set -> err_flags[1] stays 1.
